// File: rtl/sliced_vector_store.sv
// Wide packed vector updated one fixed-width slice at a time: masked writes, registered reads,
// a background clear engine and out-of-range index detection.
module sliced_vector_store #(
    parameter int unsigned WIDTH   = 1536,
    parameter int unsigned SLICE_W = 24,
    parameter int unsigned OFFSET  = 0,
    parameter int unsigned IDX_W   = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [IDX_W-1:0]   wr_index,
    input  logic [SLICE_W-1:0] wr_data,
    input  logic [SLICE_W-1:0] wr_mask,
    input  logic               rd_valid,
    input  logic [IDX_W-1:0]   rd_index,
    output logic               rd_data_valid,
    output logic [SLICE_W-1:0] rd_data,
    input  logic               clr_start,
    output logic               busy,
    output logic               err,
    output logic [WIDTH-1:0]   vec_out
);

    localparam int unsigned NSLICES = (WIDTH - OFFSET) / SLICE_W;
    // Bit offsets are computed at this width so index*SLICE_W+OFFSET never truncates.
    localparam int unsigned AW = $clog2(WIDTH) + 1;
    localparam logic [IDX_W:0] NSLICES_W = (IDX_W + 1)'(NSLICES);
    localparam logic [IDX_W:0] LAST_IDX  = (IDX_W + 1)'(NSLICES - 1);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [WIDTH-1:0]   vec_q, vec_d;
    logic [SLICE_W-1:0] rd_data_q, rd_data_d;
    logic               rd_data_valid_q;
    logic               err_q, err_d;

    logic             wr_fire, wr_in_range, rd_in_range;
    logic [AW-1:0]    wr_base, rd_base, clr_base;
    logic [WIDTH-1:0] wr_mask_full, wr_data_full, clr_mask_full;

    function automatic logic [AW-1:0] base_of(input logic [IDX_W-1:0] idx);
        return AW'(idx) * AW'(SLICE_W) + AW'(OFFSET);
    endfunction

    assign wr_fire     = wr_valid && wr_ready;
    assign wr_in_range = {1'b0, wr_index} < NSLICES_W;
    assign rd_in_range = {1'b0, rd_index} < NSLICES_W;
    assign wr_base     = base_of(wr_index);
    assign rd_base     = base_of(rd_index);
    assign clr_base    = base_of(clr_ptr_q);

    assign wr_mask_full  = WIDTH'(wr_mask) << wr_base;
    assign wr_data_full  = WIDTH'(wr_data & wr_mask) << wr_base;
    assign clr_mask_full = WIDTH'({SLICE_W{1'b1}}) << clr_base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (clr_start) state_d = StClear;
            StClear: if ({1'b0, clr_ptr_q} == LAST_IDX) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ready = (state_q == StIdle);
        busy     = (state_q == StClear);
    end

    // Writes are only accepted in idle, so a write and a clear never touch vec in the same cycle.
    always_comb begin
        vec_d     = vec_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == StClear) begin
            vec_d     = vec_q & ~clr_mask_full;
            clr_ptr_d = clr_ptr_q + 1'b1;
        end else if (clr_start) begin
            clr_ptr_d = '0;
        end
        if (wr_fire && wr_in_range) begin
            vec_d = (vec_q & ~wr_mask_full) | wr_data_full;
        end
    end

    // Reads sample vec_q, so a same-cycle write or clear to that slice is not yet visible.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_valid) begin
            rd_data_d = rd_in_range ? SLICE_W'(vec_q >> rd_base) : '0;
        end
        err_d = (wr_fire && !wr_in_range) || (rd_valid && !rd_in_range);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q           <= '0;
            clr_ptr_q       <= '0;
            rd_data_q       <= '0;
            rd_data_valid_q <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            vec_q           <= vec_d;
            clr_ptr_q       <= clr_ptr_d;
            rd_data_q       <= rd_data_d;
            rd_data_valid_q <= rd_valid;
            err_q           <= err_d;
        end
    end

    assign vec_out       = vec_q;
    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_data_valid_q;
    assign err           = err_q;

endmodule

// File: doc/sliced_vector_store.md
Name: sliced_vector_store

Overview:
- Sequential, parametrised store for a wide vector that is partitioned into fixed-width slices.
- Slice index N occupies bits [OFFSET + N*SLICE_W +: SLICE_W].
- Provides:
  - a valid/ready masked slice-write port;
  - a registered slice-read port;
  - a background clear engine;
  - out-of-range index detection.
- Used wherever a wide packed state vector is updated piecewise by index instead of being rebuilt combinationally each cycle.

Parameters:
- WIDTH, 1536: total vector width in bits.
- SLICE_W, 24: slice width in bits.
- OFFSET, 0: bit position of slice 0. Requires 0 <= OFFSET < WIDTH.
- IDX_W, 6: width of the index ports.
- NSLICES (localparam), (WIDTH-OFFSET)/SLICE_W: number of addressable slices. Value is 64 at defaults.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write port can accept.
- wr_index  in  IDX_W  target slice.
- wr_data  in  SLICE_W  write data.
- wr_mask  in  SLICE_W  per-bit enable; 1 means write this bit.
- rd_valid  in  1  read request.
- rd_index  in  IDX_W  slice to read.
- rd_data_valid  out  1  rd_data valid this cycle.
- rd_data  out  SLICE_W  read data.
- clr_start  in  1  start background clear.
- busy  out  1  clear engine active.
- err  out  1  one-cycle pulse on an out-of-range access.
- vec_out  out  WIDTH  registered full vector.

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream):
  - vec_out, rd_data, rd_data_valid, err, busy all 0.
  - FSM in IDLE; wr_ready = 1 once out of reset.
- FSM states: IDLE and CLEAR.
  - IDLE: wr_ready = 1, busy = 0.
  - IDLE → CLEAR when clr_start = 1. Clear pointer is loaded with 0.
  - clr_start while in CLEAR is ignored.
- CLEAR behaviour:
  - Each cycle, zeroes the slice at the clear pointer, then increments the pointer.
  - After slice NSLICES-1 is zeroed, returns to IDLE.
  - busy = 1 and wr_ready = 0 for exactly NSLICES cycles, starting the cycle after clr_start.
- Write acceptance: a write is accepted when wr_valid && wr_ready.
  - If wr_index < NSLICES: for each bit b, if wr_mask[b] then vec slice bit b takes wr_data[b]; otherwise the bit is unchanged.
  - The update is visible on vec_out the next cycle (latency 1).
- Write/clear in the same cycle: if clr_start and an accepted write arrive together in IDLE, the write is performed and the clear starts the next cycle, so the clear will overwrite that slice with zeros.
- Out-of-range index (index >= NSLICES, including any unreachable IDX_W codes):
  - Applies to both accepted writes and reads.
  - No vector update; err = 1 on the next cycle for one cycle.
  - For an out-of-range read: rd_data_valid = 1 and rd_data = 0.
  - A simultaneous out-of-range write and read produce a single err pulse.
- Reads:
  - Allowed in any state, including CLEAR.
  - rd_valid in cycle T gives rd_data_valid = 1 and rd_data in cycle T+1.
  - rd_data holds its value when rd_valid = 0; rd_data_valid is 0 in that case.
  - Read-before-write: a read and a write to the same slice in the same cycle return the pre-write value.
  - The same rule applies to a read of the slice being cleared that cycle.
- Bits outside the slices are never written and remain 0 after reset. These are bits below OFFSET and bits at or above OFFSET + NSLICES*SLICE_W.
- Index arithmetic: compute index*SLICE_W + OFFSET at a width sufficient for WIDTH without truncation. This must be at least clog2(WIDTH)+1 bits.
- Reset asserted mid-CLEAR or mid-read:
  - Everything returns immediately to reset values.
  - Any pending read result is discarded.

Test Plan:
- Reset, then write idx 5, data 24'hABCDEF, mask all-ones → next cycle vec_out[143:120] = 24'hABCDEF, all other bits 0; err = 0.
- Partial mask: idx 5 holds 24'hABCDEF; write data 24'h000000, mask 24'h0000FF → vec_out[143:120] = 24'hABCD00.
- Read/write collision: idx 63 holds 24'h111111; in one cycle write idx 63 = 24'h222222 and read idx 63 → rd_data = 24'h111111 with rd_data_valid = 1. A read of idx 63 the following cycle returns 24'h222222.
- Out-of-range: OFFSET = 12, WIDTH = 1536 gives NSLICES = 63. Write idx 63 → err pulses for 1 cycle and vec_out is unchanged. Read idx 63 → rd_data = 0.
- Clear sequence: fill slices 0..63 with nonzero data, then pulse clr_start.
  - busy is high for exactly 64 cycles; wr_ready is low over the same window.
  - A read of idx 10 issued mid-clear returns 0 if slice 10 has already been cleared, or the old data otherwise.
  - After the clear, vec_out = 0.
- Reset mid-clear: assert rst_n = 0 during cycle 20 of the clear → vec_out = 0, busy = 0 immediately. After release, a write to idx 0 is accepted on the first cycle.
